// File: rtl/design_select_ctrl.sv
// Design select controller: debounces a 4-bit pad select, then sequences reset/enable of one of 16 user designs.
// Latency: STABLE_CYCLES + RST_CYCLES + 1 cycles from a stable select to design_en, plus 2 with DESIGN_SELECT_SYNC_EN.
// Backpressure: none; select changes seen during the reset hold are ignored until the design is active.
module design_select_ctrl #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned RST_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [3:0]  design_select,
    output logic [3:0]  cur_sel,
    output logic [15:0] design_en,
    output logic        design_rst_n,
    output logic        force_oeb,
    output logic        busy
);
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [7:0]        RST_LAST  = 8'(RST_CYCLES - 1);

    localparam logic [1:0] SETTLE = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    logic [3:0]        sel_s;
    logic [1:0]        state;
    logic [3:0]        cand;
    logic [STAB_W-1:0] stab_cnt;
    logic [7:0]        rst_cnt;

`ifdef DESIGN_SELECT_SYNC_EN
    logic [3:0] sync_q1;
    logic [3:0] sync_q2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= design_select;
            sync_q2 <= sync_q1;
        end
    end

    assign sel_s = sync_q2;
`else
    assign sel_s = design_select;
`endif

    // Outputs are only changed on the HOLD->ACTIVE and ACTIVE->SETTLE edges, so design_en
    // always passes through zero between two different owners.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= SETTLE;
            cand         <= '0;
            cur_sel      <= '0;
            stab_cnt     <= '0;
            rst_cnt      <= '0;
            design_en    <= '0;
            design_rst_n <= 1'b0;
            force_oeb    <= 1'b1;
            busy         <= 1'b1;
        end else begin
            case (state)
                SETTLE: begin
                    if (sel_s != cand) begin
                        cand     <= sel_s;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        cur_sel <= cand;
                        rst_cnt <= '0;
                        state   <= HOLD;
                    end else if (stab_cnt != STAB_MAX) begin
                        stab_cnt <= stab_cnt + STAB_ONE;
                    end
                end
                HOLD: begin
                    if (rst_cnt == RST_LAST) begin
                        state <= ACTIVE;
                        busy  <= 1'b0;
                        // Design 0 means "no design": pads stay inputs and nothing leaves reset.
                        if (cur_sel != 4'd0) begin
                            design_en    <= 16'd1 << cur_sel;
                            design_rst_n <= 1'b1;
                            force_oeb    <= 1'b0;
                        end
                    end else begin
                        rst_cnt <= rst_cnt + 8'd1;
                    end
                end
                ACTIVE: begin
                    if (sel_s != cur_sel) begin
                        state        <= SETTLE;
                        cand         <= sel_s;
                        stab_cnt     <= '0;
                        design_en    <= '0;
                        design_rst_n <= 1'b0;
                        force_oeb    <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                default: begin
                    state        <= SETTLE;
                    stab_cnt     <= '0;
                    design_en    <= '0;
                    design_rst_n <= 1'b0;
                    force_oeb    <= 1'b1;
                    busy         <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_design_select_ctrl.sv
// Bench for design_select_ctrl: timestamp-based reference model, directed scenarios plus random select sequences.
// Sync latency follows DESIGN_SELECT_SYNC_EN as seen by this file.
module tb_design_select_ctrl;
    localparam int STABLE = 8;
    localparam int RSTC   = 4;
`ifdef DESIGN_SELECT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int EXP_LAT = LAT + STABLE + RSTC + 1;
    localparam logic [22:0] RST_VEC = {4'd0, 16'd0, 1'b0, 1'b1, 1'b1};

    localparam int M_SETTLE = 0;
    localparam int M_HOLD   = 1;
    localparam int M_ACTIVE = 2;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic [3:0]  design_select = 4'd5;
    logic [3:0]  cur_sel;
    logic [15:0] design_en;
    logic        design_rst_n;
    logic        force_oeb;
    logic        busy;
    logic [22:0] obs;

    int errors = 0;
    int checks = 0;

    design_select_ctrl #(.STABLE_CYCLES(STABLE), .RST_CYCLES(RSTC)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .design_select (design_select),
        .cur_sel       (cur_sel),
        .design_en     (design_en),
        .design_rst_n  (design_rst_n),
        .force_oeb     (force_oeb),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    assign obs = {cur_sel, design_en, design_rst_n, force_oeb, busy};

    // Reference model: edge n since reset release; a candidate is accepted once it has been
    // seen unchanged for STABLE edges, and becomes active RSTC edges after acceptance.
    logic [3:0] pin_hist[$];
    logic [3:0] m_cand, m_owner;
    int m_mode, m_run, m_hold, n;

    task automatic model_reset();
        n = 0;
        pin_hist.delete();
        m_mode = M_SETTLE;
        m_cand = 4'd0;
        m_owner = 4'd0;
        m_run = 0;
        m_hold = 0;
    endtask

    task automatic step();
        logic [3:0] s;
        @(posedge clk);
        n++;
        pin_hist.push_back(design_select);
        s = (n > LAT) ? pin_hist[n-1-LAT] : 4'd0;
        if (m_mode == M_SETTLE) begin
            if (s != m_cand) begin
                m_cand = s;
                m_run = n;
            end else if (n - m_run == STABLE) begin
                m_owner = m_cand;
                m_mode = M_HOLD;
                m_hold = n;
            end
        end else if (m_mode == M_HOLD) begin
            if (n - m_hold == RSTC) m_mode = M_ACTIVE;
        end else if (s != m_owner) begin
            m_mode = M_SETTLE;
            m_cand = s;
            m_run = n;
        end
        #1;
    endtask

    function automatic logic [22:0] exp_vec();
        logic [15:0] en;
        en = '0;
        if (m_mode == M_ACTIVE && m_owner != 4'd0) begin
            en[m_owner] = 1'b1;
            return {m_owner, en, 1'b1, 1'b0, 1'b0};
        end
        if (m_mode == M_ACTIVE) return {m_owner, en, 1'b0, 1'b1, 1'b0};
        return {m_owner, en, 1'b0, 1'b1, 1'b1};
    endfunction

    // Safety invariants on every clock while out of reset.
    logic [15:0] prev_en = '0;
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            checks++;
            if (!$onehot0(design_en) || (design_rst_n === 1'b0 && force_oeb !== 1'b1) ||
                (prev_en != 16'd0 && design_en != 16'd0 && design_en != prev_en)) begin
                errors++;
                $display("FAIL invariant t=%0t en=%h prev_en=%h rst_n=%b oeb=%b",
                         $time, design_en, prev_en, design_rst_n, force_oeb);
            end
        end
        prev_en = design_en;
    end

    task automatic test_reset();
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", obs, RST_VEC);
        end
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL reset_held got=%h exp=%h", obs, RST_VEC);
        end
        n_rst = 1'b1;
        model_reset();
    endtask

    task automatic test_power_on();
        int first_en = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (first_en < 0 && design_en == 16'h0020) first_en = i;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL power_on cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        checks++;
        if (first_en != EXP_LAT) begin
            errors++;
            $display("FAIL power_on_latency got=%0d exp=%0d", first_en, EXP_LAT);
        end
    endtask

    task automatic test_switch();
        int drop = -1;
        int up = -1;
        design_select = 4'd9;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (drop < 0 && design_en == 16'h0000) drop = i;
            if (up < 0 && design_en == 16'h0200) up = i;
            checks++;
            if (obs !== exp_vec() || design_en == 16'h0220) begin
                errors++;
                $display("FAIL switch cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        checks++;
        if (drop != LAT + 1 || up != LAT + 1 + STABLE + RSTC) begin
            errors++;
            $display("FAIL switch_timing drop=%0d up=%0d exp=%0d,%0d", drop, up, LAT + 1, LAT + 1 + STABLE + RSTC);
        end
    endtask

    task automatic test_toggle();
        int up = -1;
        for (int i = 1; i <= 32; i++) begin
            if (i <= 12) design_select = (((i - 1) / 4) % 2 == 0) ? 4'd5 : 4'd6;
            else design_select = 4'd6;
            step();
            if (up < 0 && design_en == 16'h0040) up = i;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL toggle cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            if (i > LAT + 1 && i <= 24) begin
                checks++;
                if (design_en !== 16'h0000 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL toggle_settle cyc=%0d en=%h busy=%b exp en=0000 busy=1", i, design_en, busy);
                end
            end
        end
        checks++;
        if (up != 12 + EXP_LAT) begin
            errors++;
            $display("FAIL toggle_latency got=%0d exp=%0d", up, 12 + EXP_LAT);
        end
    endtask

    task automatic test_zero();
        design_select = 4'd0;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL zero cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        checks++;
        if ({design_en, design_rst_n, force_oeb, busy} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zero_active en=%h rst_n=%b oeb=%b busy=%b exp 0000 0 1 0",
                     design_en, design_rst_n, force_oeb, busy);
        end
    endtask

    task automatic test_glitch();
        int up = -1;
        bit saw_rst = 1'b0;
        design_select = 4'd3;
        for (int i = 1; i <= 20; i++) step();
        for (int i = 1; i <= 24; i++) begin
            design_select = (i == 1) ? 4'd11 : 4'd3;
            step();
            if (design_rst_n === 1'b0) saw_rst = 1'b1;
            if (saw_rst && up < 0 && design_en == 16'h0008) up = i;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL glitch cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        checks++;
        if (!saw_rst || up != LAT + 2 + STABLE + RSTC) begin
            errors++;
            $display("FAIL glitch_rereset saw_rst=%0d up=%0d exp 1,%0d", saw_rst, up, LAT + 2 + STABLE + RSTC);
        end
    endtask

    task automatic test_reset_mid_hold();
        int up = -1;
        int guard = 0;
        design_select = 4'd7;
        while (m_mode != M_HOLD && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (m_mode != M_HOLD || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_reach guard=%0d busy=%b exp busy=1 within 40", guard, busy);
        end
        repeat (2) step();
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL mid_hold_reset got=%h exp=%h", obs, RST_VEC);
        end
        @(posedge clk);
        #3 n_rst = 1'b1;
        model_reset();
        for (int i = 1; i <= 20; i++) begin
            step();
            if (up < 0 && design_en == 16'h0080) up = i;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL mid_hold_rerun cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        checks++;
        if (up != EXP_LAT) begin
            errors++;
            $display("FAIL mid_hold_latency got=%0d exp=%0d", up, EXP_LAT);
        end
    endtask

    task automatic test_random();
        int dur;
        for (int seg = 0; seg < 40; seg++) begin
            design_select = 4'($urandom_range(0, 15));
            dur = $urandom_range(1, 24);
            for (int i = 0; i < dur; i++) begin
                step();
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL random seg=%0d cyc=%0d got=%h exp=%h", seg, i, obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_power_on();
        test_switch();
        test_toggle();
        test_zero();
        test_glitch();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/design_select_ctrl.md
DESIGN_SELECT_CTRL -- requirements
Module: design_select_ctrl

Interface
REQ-001: Parameter STABLE_CYCLES, default 1024, is the number of consecutive cycles a new select value must hold before it is accepted; legal range 2..65535.
REQ-002: Parameter RST_CYCLES, default 16, is the number of cycles the selected design is held in reset after acceptance; legal range 1..255.
REQ-003: The block SHALL have these ports: clk  input  1  system clock; all state is rising-edge.
REQ-004: n_rst  input  1  asynchronous active-low reset.
REQ-005: design_select  input  4  raw select from pads; asynchronous to clk.
REQ-006: cur_sel  output  4  accepted design number.
REQ-007: design_en  output  16  one-hot enable; bit N means design N owns the GPIOs.
REQ-008: design_rst_n  output  1  active-low reset to all user designs.
REQ-009: force_oeb  output  1  when 1, the downstream GPIO mux SHALL drive every gpio_oeb bit to 1 (all pads input).
REQ-010: busy  output  1  high in any state other than ACTIVE.

Function
REQ-011: The block SHALL implement three states: SETTLE, HOLD and ACTIVE.
REQ-012: sel_s is the select value after the input stage (see REQ-030/031).
- cand: 4-bit candidate register.
- stab_cnt: saturating counter of width clog2(STABLE_CYCLES+1).
- rst_cnt: 8-bit counter.
REQ-013: SETTLE, when sel_s != cand: cand <= sel_s and stab_cnt <= 0.
- Otherwise stab_cnt increments.
- When stab_cnt == STABLE_CYCLES-1 with sel_s == cand: cur_sel <= cand, rst_cnt <= 0, next state HOLD.
REQ-014: HOLD: rst_cnt increments each cycle and the state goes to ACTIVE on the edge where rst_cnt == RST_CYCLES-1.
- sel_s changing during HOLD SHALL be ignored until ACTIVE.
REQ-015: ACTIVE: when sel_s != cur_sel, next state SETTLE, cand <= sel_s, stab_cnt <= 0.
- Any change, including a one-cycle glitch that returns to the old value, SHALL force a full SETTLE/HOLD re-reset of the design.
REQ-016: In SETTLE and HOLD, all outputs are registered:
- design_en = 0
- design_rst_n = 0
- force_oeb = 1
- busy = 1
REQ-017: In ACTIVE with cur_sel != 0:
- design_en = 16'b1 << cur_sel
- design_rst_n = 1
- force_oeb = 0
- busy = 0
REQ-018: In ACTIVE with cur_sel == 0 (no design): design_en = 0, design_rst_n = 0, force_oeb = 1, busy = 0.
REQ-019: design_en SHALL never have more than one bit set, and SHALL be 0 for at least one cycle between any two different non-zero values.
REQ-020: force_oeb SHALL be 1 in every cycle in which design_rst_n is 0.
REQ-021: Minimum latency from a stable change of sel_s to design_en updating is STABLE_CYCLES + RST_CYCLES + 1 cycles.

Reset
REQ-022: While n_rst is low, regardless of clk:
- state = SETTLE
- cand = 0, cur_sel = 0
- stab_cnt = 0, rst_cnt = 0
- design_en = 0
- design_rst_n = 0
- force_oeb = 1
- busy = 1
- synchronizer flops = 0
REQ-023: After n_rst deasserts, the block SHALL run the normal SETTLE/HOLD sequence on the current select value before any design is enabled.
REQ-024: Reset asserted mid-HOLD or mid-SETTLE SHALL abort the sequence immediately with the values of REQ-022.

Configuration
REQ-030: With DESIGN_SELECT_SYNC_EN defined, design_select SHALL pass through a two-flop synchronizer, so sel_s lags the pins by 2 cycles.
REQ-031: Without DESIGN_SELECT_SYNC_EN, sel_s = design_select directly (0 cycles), for use when the pins are already synchronous.
- All other behaviour is identical in both configurations.

Verification
REQ-040: Bench parameters are STABLE_CYCLES=8 and RST_CYCLES=4, with DESIGN_SELECT_SYNC_EN defined.
REQ-041: Scenario: hold design_select=4'd5 through reset release -> design_en=16'h0020, design_rst_n=1, force_oeb=0, busy=0 exactly 2+8+4+1 cycles after release; before that design_en=0 and force_oeb=1.
REQ-042: Scenario: from ACTIVE sel 5, switch to 4'd9 -> within 3 cycles design_en=0, design_rst_n=0, force_oeb=1; then design_en=16'h0200 after 8+4 further cycles; design_en is never 16'h0220.
REQ-043: Scenario: toggle design_select 5->6->5->6 every 4 cycles (shorter than STABLE_CYCLES) -> block stays in SETTLE and design_en=0 throughout; it settles only after 8 stable cycles.
REQ-044: Scenario: select 4'd0 -> busy=0, design_en=0, force_oeb=1, design_rst_n=0 in ACTIVE.
REQ-045: Scenario: assert n_rst low for 1 cycle mid-HOLD -> all outputs are at REQ-022 values asynchronously, then the full 2+8+4 sequence repeats.
REQ-046: Scenario: rebuild without DESIGN_SELECT_SYNC_EN, repeat REQ-041 -> latency is 8+4+1 cycles.
